// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, drives the instruction-fetch request
// and resolves B / B.cond-CBZ-CBNZ / BR redirects with a one-bubble penalty.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [1:0]  br_type,
  input  logic        br_taken,
  input  logic [63:0] br_pc,
  input  logic [25:0] imm26,
  input  logic [18:0] imm19,
  input  logic [63:0] br_reg,
  output logic [63:0] fetch_addr,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign,
  output logic        illegal
);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    BUBBLE = 2'b10
  } state_e;

  localparam logic [1:0] BR_B    = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_REG  = 2'b10;
  localparam logic [1:0] BR_RSVD = 2'b11;

  state_e      state_r;
  state_e      state_s;
  logic [63:0] pc_r;
  logic [63:0] pc_s;
  logic        fetch_valid_r;
  logic        fetch_valid_s;
  logic        flush_r;
  logic        flush_s;
  logic        misalign_r;
  logic        misalign_s;
  logic        illegal_r;
  logic        illegal_s;
  logic        type_redirect_s;
  logic        redirect_s;
  logic [63:0] target_s;

  // Word offsets are sign-extended to 64 bits and scaled by 4.
  function automatic logic [63:0] scale_imm26(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00};
  endfunction

  function automatic logic [63:0] scale_imm19(input logic [18:0] imm);
    return {{43{imm[18]}}, imm, 2'b00};
  endfunction

  // Branch target computation and per-type taken decision
  always_comb begin
    target_s        = pc_r;
    type_redirect_s = 1'b0;
    case (br_type)
      BR_B: begin
        target_s        = br_pc + scale_imm26(imm26);
        type_redirect_s = 1'b1;
      end
      BR_COND: begin
        target_s        = br_pc + scale_imm19(imm19);
        type_redirect_s = br_taken;
      end
      BR_REG: begin
        target_s        = {br_reg[63:2], 2'b00};
        type_redirect_s = 1'b1;
      end
      default: begin
        target_s        = pc_r;
        type_redirect_s = 1'b0;
      end
    endcase
  end

  // Branches are only honoured while fetching; BUBBLE drops them.
  assign redirect_s = br_valid && (state_r == RUN) && type_redirect_s;

  // Next-state, next-PC and next pulse values; redirect beats stall beats increment
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    flush_s       = 1'b0;
    misalign_s    = 1'b0;
    illegal_s     = 1'b0;
    fetch_valid_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_s = RUN;
      end
      RUN: begin
        if (redirect_s) begin
          state_s    = BUBBLE;
          pc_s       = target_s;
          flush_s    = 1'b1;
          misalign_s = (br_type == BR_REG) && (br_reg[1:0] != 2'b00);
        end else if (stall) begin
          pc_s = pc_r;
        end else if (imem_ready) begin
          pc_s = pc_r + 64'd4;
        end else begin
          pc_s = pc_r;
        end
        illegal_s = br_valid && (br_type == BR_RSVD);
      end
      BUBBLE: begin
        state_s = RUN;
      end
      default: begin
        state_s = BOOT;
      end
    endcase
    fetch_valid_s = (state_s == RUN);
  end

  // State, PC and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
      misalign_r    <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      fetch_valid_r <= fetch_valid_s;
      flush_r       <= flush_s;
      misalign_r    <= misalign_s;
      illegal_r     <= illegal_s;
    end
  end

  assign fetch_addr  = pc_r;
  assign fetch_valid = fetch_valid_r;
  assign flush       = flush_r;
  assign misalign    = misalign_r;
  assign illegal     = illegal_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed test-plan cases followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [63:0] RST_PC = 64'h400;

  typedef struct {
    logic [63:0] addr;
    logic        fv;
    logic        fl;
    logic        mis;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_type = 2'b00;
  logic        br_taken = 1'b0;
  logic [63:0] br_pc = 64'h0;
  logic [25:0] imm26 = 26'h0;
  logic [18:0] imm19 = 19'h0;
  logic [63:0] br_reg = 64'h0;
  logic [63:0] fetch_addr;
  logic        fetch_valid;
  logic        flush;
  logic        misalign;
  logic        illegal;

  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;
  exp_t q[$];

  // model state: 0 = waiting to start, 1 = fetching, 2 = bubble after redirect
  int          m_phase = 0;
  logic [63:0] m_pc = RST_PC;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .stall(stall),
    .br_valid(br_valid), .br_type(br_type), .br_taken(br_taken), .br_pc(br_pc),
    .imm26(imm26), .imm19(imm19), .br_reg(br_reg), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .flush(flush), .misalign(misalign), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t rst_exp();
    exp_t e;
    e.addr = RST_PC; e.fv = 1'b0; e.fl = 1'b0; e.mis = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  // Expected outputs after the coming rising edge, from the current inputs.
  task automatic model_step(output exp_t e);
    longint off;
    bit     taken;
    e = rst_exp();
    if (!reset_n) begin
      m_phase = 0;
      m_pc    = RST_PC;
    end else if (m_phase != 1) begin
      m_phase = 1;
      e.addr  = m_pc;
      e.fv    = 1'b1;
    end else begin
      taken = br_valid && (br_type == 2'd0 || br_type == 2'd2 ||
                           (br_type == 2'd1 && br_taken));
      if (taken) begin
        if (br_type == 2'd0) begin
          off = longint'(imm26);
          if (off >= (longint'(1) << 25)) off = off - (longint'(1) << 26);
          m_pc = br_pc + off * 4;
        end else if (br_type == 2'd1) begin
          off = longint'(imm19);
          if (off >= (longint'(1) << 18)) off = off - (longint'(1) << 19);
          m_pc = br_pc + off * 4;
        end else begin
          m_pc = br_reg - (br_reg % 4);
          e.mis = (br_reg % 4) != 0;
        end
        m_phase = 2;
        e.fl = 1'b1;
      end else begin
        if (imem_ready && !stall) m_pc = m_pc + 4;
        e.fv  = 1'b1;
        e.ill = br_valid && (br_type == 2'd3);
      end
      e.addr = m_pc;
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step(e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Asynchronous reset assertion: outputs must return to reset values at once.
  task automatic do_reset();
    int n;
    reset_n = 1'b0;
    #1;
    chk("rst_addr", fetch_addr, RST_PC);
    chk("rst_fv", {63'd0, fetch_valid}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    n = q.size();
    q.delete();
    repeat (n) q.push_back(rst_exp());
    m_phase = 0;
    m_pc    = RST_PC;
  endtask

  task automatic no_branch();
    br_valid = 1'b0; br_type = 2'd0; br_taken = 1'b0;
  endtask

  // Monitor: one expected record per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
          e = q.pop_front();
          if (fetch_addr !== e.addr || fetch_valid !== e.fv || flush !== e.fl ||
              misalign !== e.mis || illegal !== e.ill) begin
            miscompares++;
            $display("FAIL outputs @%0t: got addr=0x%0h v=%b fl=%b mis=%b ill=%b, expected addr=0x%0h v=%b fl=%b mis=%b ill=%b",
                     $time, fetch_addr, fetch_valid, flush, misalign, illegal,
                     e.addr, e.fv, e.fl, e.mis, e.ill);
          end
        end
      end
    end
  end

  initial begin
    #1;
    imem_ready = 1'b1;
    do_reset();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("first_fetch", fetch_addr, 64'h400);
    cycle();
    chk("second_fetch", fetch_addr, 64'h404);

    imem_ready = 1'b0;
    repeat (3) cycle();
    chk("hold_not_ready", fetch_addr, 64'h404);
    imem_ready = 1'b1;
    stall = 1'b1;
    repeat (2) cycle();
    chk("hold_stall", fetch_addr, 64'h404);
    stall = 1'b0;
    cycle();
    chk("resume_inc", fetch_addr, 64'h408);

    br_valid = 1'b1; br_type = 2'd0; br_pc = 64'h100; imm26 = 26'h3FFFFFE;
    cycle();
    chk("b_target", fetch_addr, 64'hF8);
    chk("b_flush", {63'd0, flush}, 64'd1);
    no_branch();
    cycle();
    chk("b_fetch_valid", {63'd0, fetch_valid}, 64'd1);

    br_valid = 1'b1; br_type = 2'd1; br_taken = 1'b1; br_pc = 64'h0; imm19 = 19'h40000;
    cycle();
    chk("cbz_wrap", fetch_addr, 64'hFFFF_FFFF_FFF0_0000);
    no_branch();
    cycle();
    br_valid = 1'b1; br_type = 2'd1; br_taken = 1'b0;
    cycle();
    chk("cbz_not_taken_flush", {63'd0, flush}, 64'd0);
    no_branch();
    cycle();

    br_valid = 1'b1; br_type = 2'd2; br_reg = 64'h1003; stall = 1'b1;
    cycle();
    chk("br_target", fetch_addr, 64'h1000);
    chk("br_misalign", {63'd0, misalign}, 64'd1);
    stall = 1'b0;
    br_type = 2'd0; br_pc = 64'h8000; imm26 = 26'h10;
    cycle();
    chk("bubble_ignores_br", fetch_addr, 64'h1000);
    no_branch();
    cycle();

    br_valid = 1'b1; br_type = 2'd3;
    cycle();
    chk("illegal_pulse", {63'd0, illegal}, 64'd1);
    no_branch();
    cycle();

    br_valid = 1'b1; br_type = 2'd0; br_pc = 64'h2000; imm26 = 26'h4;
    cycle();
    no_branch();
    do_reset();
    cycle();
    reset_n = 1'b1;
    cycle();

    for (int i = 0; i < 500; i++) begin
      imem_ready = ($urandom_range(3) != 0);
      stall      = ($urandom_range(3) == 0);
      br_valid   = ($urandom_range(2) == 0);
      br_type    = 2'($urandom_range(3));
      br_taken   = 1'($urandom_range(1));
      br_pc      = {$urandom, $urandom};
      imm26      = 26'($urandom);
      imm19      = 19'($urandom);
      br_reg     = {$urandom, $urandom};
      if ($urandom_range(99) == 0) begin
        do_reset();
        cycle();
        reset_n = 1'b1;
      end
      cycle();
    end

    no_branch();
    @(negedge clk);
    #1;
    done = 1'b1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
